shift_reg_seq: RTL
==================

# shift_reg_seq

Parametrised shift register with four shift modes and a built-in burst sequencer that performs a counted run of shifts from a single Start request. It replaces the fixed 8-bit load/shift-right register in the add-shift multiplier datapath and in later serial blocks. Single-step shifting is preserved, and the control unit can hand off an N-position shift with a Busy/Done handshake.

## Interface
- WIDTH, 8: register width in bits; must be ≥ 2.
- CW, $clog2(WIDTH+1): width of Count.
- Clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high.
- Load  input  1  parallel load of D.
- D  input  WIDTH  parallel load data.
- Shift_En  input  1  single shift this edge (idle only).
- Start  input  1  begin burst of Count shifts (idle only).
- Count  input  CW  burst length, sampled with Start.
- Mode  input  2  00 logical right, 01 arithmetic right, 10 left, 11 rotate right.
- Shift_In  input  1  serial input bit; used by modes 00 and 10.
- Data_Out  output  WIDTH  register contents.
- Shift_Out  output  1  bit ejected by the next shift.
- Busy  output  1  burst in progress.
- Done  output  1  one-cycle pulse when a burst completes.

## Operation
- States: IDLE, RUN. Internal registers:
  - cnt (CW bits).
  - mode_q: mode latched at Start.
- Edge priority: Reset > Load > Start (IDLE) > Shift_En (IDLE). Start and Shift_En are ignored in RUN.
- Reset:
  - Data_Out=0, cnt=0, mode_q=00, state=IDLE.
  - Busy=0, Done=0. Shift_Out is therefore 0.
  - Reset mid-burst aborts the burst with no Done.
- Load:
  - Data_Out<=D in either state.
  - In RUN, Load aborts the burst: state<=IDLE, no Done, and no shift occurs that edge.
- Shift step, applied to Data_Out under the effective mode:
  - 00: {Shift_In, Data_Out[WIDTH-1:1]}
  - 01: {Data_Out[WIDTH-1], Data_Out[WIDTH-1:1]}
  - 10: {Data_Out[WIDTH-2:0], Shift_In}
  - 11: {Data_Out[0], Data_Out[WIDTH-1:1]}
  - Shift_In is ignored in modes 01 and 11.
- Effective mode is mode_q in RUN and Mode in IDLE.
- Shift_Out is combinational: Data_Out[WIDTH-1] for effective mode 10, otherwise Data_Out[0].
- Shift_En in IDLE: one shift using Mode. There is no Done and no state change.
- Start in IDLE with Count=k:
  - k>0: cnt<=k, mode_q<=Mode, state<=RUN. No shift on the Start edge.
  - k=0: no shift, stays IDLE, Done=1 for the next cycle.
- RUN, each edge:
  - One shift using mode_q; cnt<=cnt-1.
  - When cnt==1: state<=IDLE, Done<=1.
- Count values above WIDTH are legal and shift exactly Count times. Rotate by WIDTH restores the value; logical/left by ≥WIDTH yields all-Shift_In.
- Busy = (state==RUN). Done is registered and cleared on every edge where it is not set.

## Timing
- Single shift: Data_Out updates on the edge sampling Shift_En (latency 1).
- Burst with Start sampled at edge 0 and Count=k>0:
  - Shifts occur on edges 1..k.
  - Busy is high during cycles following edges 0..k-1 (exactly k cycles).
  - Done is high for one cycle following edge k, and Data_Out holds the final value in that same cycle.
- Back-to-back bursts: Start may be asserted in the Done cycle and is accepted. Minimum burst period is k+1 cycles.
- Mode and Shift_In changes during RUN: Mode has no effect; Shift_In is sampled each shift edge.

## Structure
- Package shift_pkg:
  - typedef enum logic [1:0] shift_mode_t {SH_LSR, SH_ASR, SH_LSL, SH_ROR}
  - typedef enum logic {ST_IDLE, ST_RUN} seq_state_t
- Sub-module shift_unit: combinational, parametrised WIDTH. Inputs: value, mode, Shift_In. Outputs: next value, ejected bit. Instantiated once; supplies both the shift result and Shift_Out.
- Top level holds Data_Out, the FSM, cnt, mode_q and the Done register.

## Test plan
Each scenario uses WIDTH=8.
- Reset: assert Reset with Load=1, D=8'hFF in the same cycle → Data_Out=8'h00, Busy=0, Done=0, Shift_Out=0.
- Single shift: Load 8'hB5, then Mode=00, Shift_In=1, Shift_En for 1 cycle → Data_Out=8'hDA, Shift_Out=0, Done never asserted.
- Arithmetic burst: Load 8'h96, Start with Count=3, Mode=01 → Busy high 3 cycles, Data_Out steps CB, E5, F2, then Done high 1 cycle. Changing Mode mid-burst has no effect.
- Left and rotate bursts:
  - Load 8'hA7, Count=4, Mode=10, Shift_In=0 → 8'h70.
  - Load 8'h3C, Count=8, Mode=11 → 8'h3C, with Done after exactly 9 cycles from Start.
- Abort: Load 8'hFF, Start Count=5 Mode=00 Shift_In=0, then Load D=8'h12 in the second RUN cycle → Data_Out=8'h12, Busy=0 next cycle, Done never pulses. Repeat using Reset instead of Load → Data_Out=8'h00, no Done.
- Edge cases:
  - Start with Count=0 → Done for 1 cycle, Busy never high, Data_Out unchanged.
  - Start or Shift_En while Busy → ignored, burst length unchanged.
  - Start in the Done cycle → new burst accepted.

Source files
------------

// File: rtl/shift_reg_seq_pkg.sv
// Shared types for the shift register with burst sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSR = 2'b00,
        SH_ASR = 2'b01,
        SH_LSL = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/shift_reg_seq_if.sv
// Control/data bundle between the control unit (master) and shift_reg_seq (slave).
interface shift_reg_seq_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             Load;
    logic [WIDTH-1:0] D;
    logic             Shift_En;
    logic             Start;
    logic [CW-1:0]    Count;
    logic [1:0]       Mode;
    logic             Shift_In;
    logic [WIDTH-1:0] Data_Out;
    logic             Shift_Out;
    logic             Busy;
    logic             Done;

    modport master (
        output Load, D, Shift_En, Start, Count, Mode, Shift_In,
        input  Data_Out, Shift_Out, Busy, Done
    );

    modport slave (
        input  Load, D, Shift_En, Start, Count, Mode, Shift_In,
        output Data_Out, Shift_Out, Busy, Done
    );
endinterface

// File: rtl/shift_reg_seq_shift_unit.sv
// Combinational one-position shifter; also reports the bit the shift ejects.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  shift_mode_t      mode,
    input  logic             Shift_In,
    output logic [WIDTH-1:0] next_value,
    output logic             ejected
);

    // Next value and ejected bit for the selected mode
    always_comb begin
        next_value = value;
        ejected    = value[0];
        case (mode)
            SH_LSR: next_value = {Shift_In, value[WIDTH-1:1]};
            SH_ASR: next_value = {value[WIDTH-1], value[WIDTH-1:1]};
            SH_LSL: begin
                next_value = {value[WIDTH-2:0], Shift_In};
                ejected    = value[WIDTH-1];
            end
            SH_ROR: next_value = {value[0], value[WIDTH-1:1]};
            default: next_value = value;
        endcase
    end

endmodule

// File: rtl/shift_reg_seq.sv
// Parametrised shift register with single-step shifting and a counted burst sequencer.
module shift_reg_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic           Clk,
    input  logic           Reset,
    shift_reg_seq_if.slave bus
);

    seq_state_t       state;
    logic [CW-1:0]    cnt;
    shift_mode_t      mode_q;
    logic [WIDTH-1:0] data_q;
    logic             done_q;
    shift_mode_t      eff_mode;
    logic [WIDTH-1:0] shifted;
    logic             ejected;

    // Mode is frozen for the whole burst; live Mode applies only while idle
    always_comb begin
        eff_mode = (state == ST_RUN) ? mode_q : shift_mode_t'(bus.Mode);
    end

    shift_unit #(.WIDTH(WIDTH)) u_shift (
        .value      (data_q),
        .mode       (eff_mode),
        .Shift_In   (bus.Shift_In),
        .next_value (shifted),
        .ejected    (ejected)
    );

    // Register, sequencer FSM and Done pulse; priority Reset > Load > Start > Shift_En
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_q <= '0;
            cnt    <= '0;
            mode_q <= SH_LSR;
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.Load) begin
                // Load also aborts a running burst without a Done pulse
                data_q <= bus.D;
                state  <= ST_IDLE;
            end else if (state == ST_IDLE) begin
                if (bus.Start) begin
                    if (bus.Count != '0) begin
                        cnt    <= bus.Count;
                        mode_q <= shift_mode_t'(bus.Mode);
                        state  <= ST_RUN;
                    end else begin
                        done_q <= 1'b1;
                    end
                end else if (bus.Shift_En) begin
                    data_q <= shifted;
                end
            end else begin
                data_q <= shifted;
                cnt    <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state  <= ST_IDLE;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.Data_Out  = data_q;
    assign bus.Shift_Out = ejected;
    assign bus.Busy      = (state == ST_RUN);
    assign bus.Done      = done_q;

endmodule
